// File: rtl/wb_mprj_splitter_if.sv
// Host-side Wishbone classic bus between the Caravel management port and the splitter.
`timescale 1ns/1ps
interface wb_mprj_splitter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, wdata, input rdata, ack);
  modport slave  (input cyc, stb, we, sel, adr, wdata, output rdata, ack);
endinterface

// File: rtl/wb_mprj_splitter.sv
// Routes each host Wishbone request to one of two macro windows and error-terminates
// unmapped or unresponsive accesses; only the selected macro ever sees cyc/stb.
`timescale 1ns/1ps
module wb_mprj_splitter #(
  parameter logic [31:0] BASE0    = 32'h3000_0000,
  parameter logic [31:0] BASE1    = 32'h3000_1000,
  parameter logic [31:0] MASK     = 32'hFFFF_F000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  wb_mprj_splitter_if.slave wbs,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m0_cyc_o,
  output logic        m0_stb_o,
  output logic        m1_cyc_o,
  output logic        m1_stb_o,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m0_ack_i,
  input  logic        m1_ack_i,
  input  logic        clr_err_i,
  output logic        err_decode_o,
  output logic        err_timeout_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tgt_q, tgt_d;
  logic [31:0] rsp_q, rsp_d;
  logic        rsp_load, latch_req, set_dec, set_to;
  logic        hit0, hit1, sel_ack;
  logic [31:0] sel_dat;

  assign hit0    = (wbs.adr & MASK) == BASE0;
  assign hit1    = (wbs.adr & MASK) == BASE1;
  assign sel_ack = tgt_q ? m1_ack_i : m0_ack_i;
  assign sel_dat = tgt_q ? m1_dat_i : m0_dat_i;

  // NOTE: state is registered with <= so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    rsp_d     = ERR_DATA;
    rsp_load  = 1'b0;
    latch_req = 1'b0;
    set_dec   = 1'b0;
    set_to    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wbs.cyc && wbs.stb) begin
          latch_req = 1'b1;
          if (hit0 || hit1) begin
            tgt_d   = !hit0;
            state_d = ACCESS;
          end else begin
            rsp_load = 1'b1;
            set_dec  = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ACCESS: begin
        if (!wbs.cyc) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          // An ack on the terminal count cycle still wins over the timeout.
          rsp_load = 1'b1;
          rsp_d    = sel_dat;
          state_d  = RESP;
        end else if (cnt_q == TERM) begin
          rsp_load = 1'b1;
          set_to   = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q         <= '0;
      tgt_q         <= 1'b0;
      rsp_q         <= '0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
      m_we_o        <= 1'b0;
      m_sel_o       <= '0;
      err_decode_o  <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      if (rsp_load) rsp_q <= rsp_d;
      if (latch_req) begin
        m_adr_o <= wbs.adr;
        m_dat_o <= wbs.wdata;
        m_we_o  <= wbs.we;
        m_sel_o <= wbs.sel;
      end
      err_decode_o  <= set_dec | (err_decode_o  & ~clr_err_i);
      err_timeout_o <= set_to  | (err_timeout_o & ~clr_err_i);
    end
  end

  // Strobes come straight from the registered state, so reset removes them at once.
  assign m0_cyc_o  = (state_q == ACCESS) && !tgt_q;
  assign m0_stb_o  = m0_cyc_o;
  assign m1_cyc_o  = (state_q == ACCESS) && tgt_q;
  assign m1_stb_o  = m1_cyc_o;
  assign wbs.ack   = (state_q == RESP);
  assign wbs.rdata = rsp_q;

endmodule

// File: doc/wb_mprj_splitter.md
# wb_mprj_splitter

Wishbone (classic, single-cycle-strobe) bridge between the Caravel management-side slave port and the two Neuromorphic_X1_wb macro instances in the user project wrapper. It gives each macro exclusive use of the bus. It decodes each host request into one of two 4 KB windows, registers it, and drives only the selected macro's cyc/stb. It returns that macro's data/ack to the host, and error-terminates unmapped or unresponsive accesses with a bus-timeout counter.

## Interface
- BASE0, 32'h3000_0000, window base for macro 0
- BASE1, 32'h3000_1000, window base for macro 1
- MASK, 32'hFFFF_F000, window mask; a hit means (adr & MASK) == BASEk
- TIMEOUT, 255, cycles to wait for a slave ack (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on decode error or timeout

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host request
- wbs_sel_i  in  4  byte enables
- wbs_adr_i, wbs_dat_i  in  32 each  host address / write data
- wbs_ack_o  out  1  host acknowledge
- wbs_dat_o  out  32  host read data
- m_adr_o, m_dat_o  out  32 each  latched address / write data, shared by both macros
- m_we_o  out  1  latched write enable, shared
- m_sel_o  out  4  latched byte enables, shared
- m0_cyc_o, m0_stb_o, m1_cyc_o, m1_stb_o  out  1 each  per-macro strobes
- m0_dat_i, m1_dat_i  in  32 each  macro read data
- m0_ack_i, m1_ack_i  in  1 each  macro acknowledges
- clr_err_i  in  1  one-cycle pulse that clears the sticky error flags
- err_decode_o, err_timeout_o  out  1 each  sticky error flags

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, with wbs_cyc_i & wbs_stb_i & !wbs_ack_o:
  - Latch adr, dat, we and sel into the m_* registers.
  - Decode. BASE0 takes priority if both windows match.
  - If mapped: record target k, go to ACCESS, and assert mk_cyc_o/mk_stb_o. The other macro's strobes stay 0.
  - If unmapped: load ERR_DATA into the response register, set err_decode_o, go to RESP.
- ACCESS:
  - Hold the strobes and the m_* outputs stable.
  - Count cycles from 0.
  - Acks from the non-selected macro are ignored.
  - On mk_ack_i: capture mk_dat_i, drop the strobes, go to RESP.
  - If the count reaches TIMEOUT-1 with no ack: drop the strobes, load ERR_DATA, set err_timeout_o, go to RESP.
  - If an ack arrives on the terminal count cycle, the ack wins.
  - If wbs_cyc_i falls (host abort): drop the strobes, go to IDLE, no host ack, no flag set.
- RESP: wbs_ack_o = 1 for exactly one cycle, wbs_dat_o = response register. Then go to IDLE.
- wbs_dat_o holds its last value outside RESP.
- Writes return the captured slave data, or ERR_DATA on error. The host ignores it.
- Sticky flags:
  - Set by the events above.
  - Cleared by clr_err_i.
  - If a set and clr_err_i occur in the same cycle, the set wins.
- The window offset is not stripped: m_adr_o carries the full host address.

## Timing
- Reset (asynchronous, wb_rst_ni low):
  - FSM to IDLE, counter 0.
  - All outputs 0, including wbs_dat_o, m_adr_o, m_dat_o and m_sel_o.
  - Takes effect immediately, mid-transaction included. Strobes drop with no host ack.
- Mapped access:
  - Request sampled at edge 0, strobes high from edge 0.
  - A slave with a combinational ack in that cycle is sampled at edge 1, and wbs_ack_o is high in the cycle after edge 1.
  - Host latency = slave ack latency + 2 cycles.
- Unmapped access: wbs_ack_o is high in the cycle after the request edge (latency 1).
- Timeout access: wbs_ack_o is high exactly TIMEOUT+1 cycles after the request edge.
- Back-to-back requests:
  - A request present in the cycle after RESP is accepted from IDLE normally.
  - No request is accepted while wbs_ack_o = 1.
- The strobes never overlap: at most one mk_stb_o is high in any cycle.

## Test plan
- Read 0x3000_0010, m0 acks 3 cycles after its strobe with 0x1234_5678 → m1 strobes never rise; wbs_ack_o one cycle with wbs_dat_o = 0x1234_5678; flags 0.
- Write 0x3000_1004, data 0xA5A5_A5A5, sel 4'b0011 → m1_stb_o high with m_adr_o = 0x3000_1004, m_dat_o = 0xA5A5_A5A5, m_sel_o = 3, m_we_o = 1; one host ack after m1_ack_i.
- Read 0x3000_2000 → no macro strobe; ack 1 cycle later with 0xDEAD_BEEF; err_decode_o = 1 until a clr_err_i pulse, then 0.
- TIMEOUT = 8, m0 never acks → strobe high for 8 cycles, then dropped; host ack at cycle 9 with 0xDEAD_BEEF; err_timeout_o = 1.
- m1_ack_i pulses during an m0 access, then m0 acks with 0x0000_0001 → stray ack ignored; wbs_dat_o = 0x0000_0001.
- Host drops wbs_cyc_i in ACCESS, and separately wb_rst_ni is pulsed low in ACCESS → strobes drop, no wbs_ack_o, flags unchanged for the abort; all outputs 0 immediately on reset.
